// File: rtl/ul8_bus_pkg.sv
// Shared types and constants for the 8-bit register bus transfer sequencer.
package ul8_bus_pkg;

  localparam int DATA_W       = 8;
  localparam int NUM_REGS_DEF = 8;
  localparam int IDX_W_DEF    = 3;
  // Queue entries carry indices at this width so any IDX_W up to it fits.
  localparam int IDX_W_MAX    = 8;

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    LATCH,
    RELEASE
  } xfer_state_t;

  typedef struct packed {
    logic [IDX_W_MAX-1:0] src;
    logic [IDX_W_MAX-1:0] dst;
  } xfer_req_t;

  function automatic logic req_legal(input xfer_req_t r, input int num_regs);
    return (r.src != r.dst) && (int'(r.src) < num_regs) && (int'(r.dst) < num_regs);
  endfunction

endpackage

// File: rtl/xfer_fifo.sv
// Synchronous request queue of xfer_req_t; pointers carry one extra wrap bit
// so full and empty are distinguishable without a separate counter.
module xfer_fifo
  import ul8_bus_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      push,
  input  xfer_req_t push_data,
  input  logic      pop,
  output logic      full,
  output logic      empty,
  output xfer_req_t head
);

  localparam int PTR_W = $clog2(DEPTH);

  xfer_req_t        mem_q [DEPTH];
  logic [PTR_W:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]   rd_ptr_q, rd_ptr_d;
  logic             do_push;
  logic             do_pop;

  assign full    = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                   (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem_q[rd_ptr_q[PTR_W-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + (PTR_W+1)'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + (PTR_W+1)'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset; only the pointers decide what is valid.
  always_ff @(posedge clk) begin
    if (!reset && do_push) mem_q[wr_ptr_q[PTR_W-1:0]] <= push_data;
  end

endmodule

// File: rtl/bus_xfer_sequencer.sv
// Queues register-to-register transfers and sequences the bus write/load strobes.
// Optional BUS_SNOOP_EN adds bus_data/last_data and captures the transferred value.
module bus_xfer_sequencer
  import ul8_bus_pkg::*;
#(
  parameter int NUM_REGS   = NUM_REGS_DEF,
  parameter int IDX_W      = IDX_W_DEF,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [IDX_W-1:0]    req_src,
  input  logic [IDX_W-1:0]    req_dst,
  output logic [NUM_REGS-1:0] write_en,
  output logic [NUM_REGS-1:0] load_en,
  output logic                busy,
  output logic                done,
  output logic                err
`ifdef BUS_SNOOP_EN
  ,
  input  logic [DATA_W-1:0]   bus_data,
  output logic [DATA_W-1:0]   last_data
`endif
);

  xfer_state_t         state_q, state_d;
  xfer_req_t           cur_q, cur_d;
  xfer_req_t           push_req;
  xfer_req_t           head;
  logic                fifo_full;
  logic                fifo_empty;
  logic                pop;
  logic                head_legal;
  logic [NUM_REGS-1:0] write_q, write_d;
  logic [NUM_REGS-1:0] load_q, load_d;
  logic                done_q, done_d;
  logic                err_q, err_d;

  function automatic logic [NUM_REGS-1:0] decode(input logic [IDX_W_MAX-1:0] idx);
    logic [NUM_REGS-1:0] mask;
    mask = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (idx == IDX_W_MAX'(i)) mask[i] = 1'b1;
    end
    return mask;
  endfunction

  assign push_req.src = IDX_W_MAX'(req_src);
  assign push_req.dst = IDX_W_MAX'(req_dst);

  xfer_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (req_valid),
    .push_data(push_req),
    .pop      (pop),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .head     (head)
  );

  assign head_legal = req_legal(head, NUM_REGS);

  // Strobes are registered from the state, so the bus pattern lags the state by one cycle.
  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    pop     = 1'b0;
    write_d = '0;
    load_d  = '0;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE, RELEASE: begin
        done_d  = (state_q == RELEASE);
        state_d = IDLE;
        if (!fifo_empty) begin
          pop = 1'b1;
          if (head_legal) begin
            cur_d   = head;
            state_d = DRIVE;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      DRIVE: begin
        write_d = decode(cur_q.src);
        state_d = LATCH;
      end
      LATCH: begin
        write_d = decode(cur_q.src);
        load_d  = decode(cur_q.dst);
        state_d = RELEASE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cur_q   <= '0;
      write_q <= '0;
      load_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      write_q <= write_d;
      load_q  <= load_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign write_en  = write_q;
  assign load_en   = load_q;
  assign done      = done_q;
  assign err       = err_q;
  assign req_ready = !fifo_full;
  assign busy      = (state_q != IDLE) || !fifo_empty;

`ifdef BUS_SNOOP_EN
  logic [DATA_W-1:0] last_q, last_d;

  // Capture on the same edge that the destination register loads.
  always_comb begin
    last_d = last_q;
    if (|load_q) last_d = bus_data;
  end

  always_ff @(posedge clk) begin
    if (reset) last_q <= '0;
    else       last_q <= last_d;
  end

  assign last_data = last_q;
`endif

endmodule

// File: tb/tb_bus_xfer_sequencer.sv
// Self-checking bench for bus_xfer_sequencer with a register-file model on the bus.
// Build with BUS_SNOOP_EN defined to also check last_data capture.
module tb_bus_xfer_sequencer;

  localparam int NR = 8;
  localparam int IW = 4;
  localparam int FD = 4;

  logic          clk;
  logic          reset;
  logic          req_valid;
  logic          req_ready;
  logic [IW-1:0] req_src;
  logic [IW-1:0] req_dst;
  logic [NR-1:0] write_en;
  logic [NR-1:0] load_en;
  logic          busy;
  logic          done;
  logic          err;
  logic [7:0]    busVal;
`ifdef BUS_SNOOP_EN
  logic [7:0]    last_data;
`endif

  bus_xfer_sequencer #(
    .NUM_REGS  (NR),
    .IDX_W     (IW),
    .FIFO_DEPTH(FD)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_src  (req_src),
    .req_dst  (req_dst),
    .write_en (write_en),
    .load_en  (load_en),
    .busy     (busy),
    .done     (done),
    .err      (err)
`ifdef BUS_SNOOP_EN
    ,
    .bus_data (busVal),
    .last_data(last_data)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int vecCount  = 0;
  int missCount = 0;
  int doneCount = 0;
  int errCount  = 0;
  int cycle     = 0;

  typedef struct {
    bit         legal;
    int         src;
    int         dst;
    logic [7:0] val;
  } exp_t;

  exp_t       expQ[$];
  int         doneCycle[$];
  logic [7:0] refRegs [NR];

  // Register file model: the one driving register puts its value on the bus.
  logic [7:0] regs [NR];
  logic       presetEn;
  int         presetIdx;
  logic [7:0] presetVal;

  always_comb begin
    busVal = '0;
    for (int i = 0; i < NR; i++) if (write_en[i]) busVal = regs[i];
  end

  always @(posedge clk) begin
    cycle <= cycle + 1;
    if (presetEn) regs[presetIdx] <= presetVal;
    for (int i = 0; i < NR; i++) if (load_en[i]) regs[i] <= busVal;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecCount++;
    if (act !== exp) begin
      missCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  // Monitor: invariants every cycle plus in-order scoreboard of done/err events.
  logic [NR-1:0] prevWrite;
  logic [NR-1:0] latchWrite;
  logic [NR-1:0] latchLoad;

  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      prevWrite  = '0;
      latchWrite = '0;
      latchLoad  = '0;
    end else begin
      checkOutput("inv_write_onehot", 32'($countones(write_en) <= 1), 32'd1);
      checkOutput("inv_load_onehot", 32'($countones(load_en) <= 1), 32'd1);
      checkOutput("inv_no_same_reg", 32'(write_en & load_en), 32'd0);
      if (load_en != '0) begin
        checkOutput("drive_before_latch", 32'(prevWrite), 32'(write_en));
        latchWrite = write_en;
        latchLoad  = load_en;
      end
      if (done) begin
        doneCount++;
        doneCycle.push_back(cycle);
        if (expQ.size() == 0) begin
          checkOutput("unexpected_done", 32'd1, 32'd0);
        end else begin
          e = expQ.pop_front();
          checkOutput("done_for_legal", 32'(e.legal), 32'd1);
          if (e.legal) begin
            checkOutput("xfer_write_src", 32'(latchWrite), 32'(NR'(1) << e.src));
            checkOutput("xfer_load_dst", 32'(latchLoad), 32'(NR'(1) << e.dst));
`ifdef BUS_SNOOP_EN
            checkOutput("snoop_last_data", 32'(last_data), 32'(e.val));
`endif
          end
        end
      end
      if (err) begin
        errCount++;
        if (expQ.size() == 0) begin
          checkOutput("unexpected_err", 32'd1, 32'd0);
        end else begin
          e = expQ.pop_front();
          checkOutput("err_for_illegal", 32'(e.legal), 32'd0);
        end
      end
      prevWrite = write_en;
    end
  end

  task automatic presetReg(input int idx, input logic [7:0] val);
    presetEn  = 1'b1;
    presetIdx = idx;
    presetVal = val;
    @(negedge clk);
    presetEn  = 1'b0;
    refRegs[idx] = val;
  endtask

  // Called on a negedge; returns on the negedge after the accepting edge.
  task automatic applyStimulus(input int s, input int d);
    int   g;
    exp_t e;
    g = 0;
    req_valid = 1'b1;
    req_src   = IW'(s);
    req_dst   = IW'(d);
    while (!req_ready && g < 100) begin
      @(negedge clk);
      g++;
    end
    if (g >= 100) begin
      checkOutput("push_timeout", 32'd1, 32'd0);
    end else begin
      e.legal = (s != d) && (s < NR) && (d < NR);
      e.src   = s;
      e.dst   = d;
      e.val   = '0;
      if (e.legal) begin
        e.val        = refRegs[s];
        refRegs[d]   = refRegs[s];
      end
      expQ.push_back(e);
    end
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic applyReset();
    reset = 1'b1;
    @(negedge clk);
    checkOutput("rst_write_en", 32'(write_en), 32'd0);
    checkOutput("rst_load_en", 32'(load_en), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_err", 32'(err), 32'd0);
    checkOutput("rst_req_ready", 32'(req_ready), 32'd1);
    checkOutput("rst_busy", 32'(busy), 32'd0);
`ifdef BUS_SNOOP_EN
    checkOutput("rst_last_data", 32'(last_data), 32'd0);
`endif
    @(negedge clk);
    reset = 1'b0;
    expQ.delete();
  endtask

  task automatic waitIdle(input string name);
    int g;
    g = 0;
    while ((busy || expQ.size() != 0) && g < 300) begin
      @(negedge clk);
      g++;
    end
    checkOutput({name, "_drain"}, 32'(g < 300), 32'd1);
    if (g >= 300) expQ.delete();
    @(negedge clk);
  endtask

  typedef struct {
    logic [NR-1:0] w;
    logic [NR-1:0] l;
    logic          d;
    logic          b;
  } cyc_t;

  typedef struct {
    int src;
    int dst;
    bit expErr;
  } vec_t;

  cyc_t timTab [6];
  vec_t vecTab [8];

  initial begin
    int d0;
    int e0;
    int g;
    bit sawStrobe;
    int s;
    int d;

    timTab[0] = '{w: 8'h00, l: 8'h00, d: 1'b0, b: 1'b1};
    timTab[1] = '{w: 8'h00, l: 8'h00, d: 1'b0, b: 1'b1};
    timTab[2] = '{w: 8'h04, l: 8'h00, d: 1'b0, b: 1'b1};
    timTab[3] = '{w: 8'h04, l: 8'h20, d: 1'b0, b: 1'b1};
    timTab[4] = '{w: 8'h00, l: 8'h00, d: 1'b1, b: 1'b0};
    timTab[5] = '{w: 8'h00, l: 8'h00, d: 1'b0, b: 1'b0};

    vecTab[0] = '{src: 3,  dst: 3, expErr: 1'b1};
    vecTab[1] = '{src: 9,  dst: 1, expErr: 1'b1};
    vecTab[2] = '{src: 1,  dst: 9, expErr: 1'b1};
    vecTab[3] = '{src: 0,  dst: 7, expErr: 1'b0};
    vecTab[4] = '{src: 7,  dst: 0, expErr: 1'b0};
    vecTab[5] = '{src: 8,  dst: 2, expErr: 1'b1};
    vecTab[6] = '{src: 15, dst: 15, expErr: 1'b1};
    vecTab[7] = '{src: 5,  dst: 6, expErr: 1'b0};

    reset     = 1'b1;
    req_valid = 1'b0;
    req_src   = '0;
    req_dst   = '0;
    presetEn  = 1'b0;
    presetIdx = 0;
    presetVal = '0;
    @(negedge clk);
    for (int i = 0; i < NR; i++) presetReg(i, 8'(8'h11 * (i + 1)));

    $display("[TB] reset and single transfer timing");
    applyReset();
    @(negedge clk);
    applyStimulus(2, 5);
    for (int i = 0; i < 6; i++) begin
      checkOutput($sformatf("t1_write_c%0d", i), 32'(write_en), 32'(timTab[i].w));
      checkOutput($sformatf("t1_load_c%0d", i), 32'(load_en), 32'(timTab[i].l));
      checkOutput($sformatf("t1_done_c%0d", i), 32'(done), 32'(timTab[i].d));
      checkOutput($sformatf("t1_busy_c%0d", i), 32'(busy), 32'(timTab[i].b));
      @(negedge clk);
    end
    waitIdle("t1");

    $display("[TB] legality vector table");
    foreach (vecTab[i]) begin
      d0 = doneCount;
      e0 = errCount;
      sawStrobe = 1'b0;
      applyStimulus(vecTab[i].src, vecTab[i].dst);
      g = 0;
      while (doneCount == d0 && errCount == e0 && g < 30) begin
        if (write_en != '0 || load_en != '0) sawStrobe = 1'b1;
        @(negedge clk);
        g++;
      end
      checkOutput($sformatf("vec%0d_err", i), 32'(errCount - e0), 32'(vecTab[i].expErr));
      checkOutput($sformatf("vec%0d_done", i), 32'(doneCount - d0), 32'(!vecTab[i].expErr));
      if (vecTab[i].expErr) checkOutput($sformatf("vec%0d_no_strobe", i), 32'(sawStrobe), 32'd0);
      waitIdle($sformatf("vec%0d", i));
    end

    $display("[TB] back-to-back burst filling the queue");
    doneCycle.delete();
    applyStimulus(0, 1);
    applyStimulus(2, 3);
    applyStimulus(4, 5);
    applyStimulus(6, 7);
    applyStimulus(1, 2);
    applyStimulus(3, 4);
    checkOutput("t3_ready_low_when_full", 32'(req_ready), 32'd0);
    waitIdle("t3");
    checkOutput("t3_done_count", 32'(doneCycle.size()), 32'd6);
    for (int i = 1; i < 6 && i < doneCycle.size(); i++)
      checkOutput($sformatf("t3_spacing_%0d", i), 32'(doneCycle[i] - doneCycle[i-1]), 32'd3);

    $display("[TB] reset during latch");
    d0 = doneCount;
    applyStimulus(1, 0);
    g = 0;
    while (load_en == '0 && g < 20) begin
      @(negedge clk);
      g++;
    end
    checkOutput("t4_reached_latch", 32'(load_en), 32'h01);
    applyReset();
    repeat (8) @(negedge clk);
    checkOutput("t4_no_done", 32'(doneCount - d0), 32'd0);
    for (int i = 0; i < NR; i++) refRegs[i] = regs[i];

    $display("[TB] bus value transfer");
    presetReg(4, 8'hA5);
    applyStimulus(4, 6);
    waitIdle("t5");
    checkOutput("t5_reg6", 32'(regs[6]), 32'hA5);
`ifdef BUS_SNOOP_EN
    checkOutput("t5_last_data", 32'(last_data), 32'hA5);
`endif

    $display("[TB] randomized requests");
    for (int n = 0; n < 60; n++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      s = $urandom_range(0, 9);
      d = $urandom_range(0, 9);
      applyStimulus(s, d);
    end
    waitIdle("rand");
    for (int i = 0; i < NR; i++)
      checkOutput($sformatf("rand_reg%0d", i), 32'(regs[i]), 32'(refRegs[i]));

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
